// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for the elastic pipeline stage register.
package pipe_stage_reg_pkg;

   // addi x0,x0,0 -- the instruction a drained stage presents downstream
   localparam logic [31:0] INST_NOP = 32'h00000013;

   // Occupancy of the stage: no entry, main only, main plus skid
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stage_state_t;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register carrying {pc, pc_next, instr, data} between two
// core stages, with optional two-entry skid buffer, flush to bubble and a
// saturating back-pressure counter.
//
// Handshake: an entry moves in on a cycle where in_valid && in_ready, and
// moves out on a cycle where out_valid && out_ready. A producer holding
// valid keeps its fields stable until the transfer; ready never depends on
// valid on the same side.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int          DATA_W       = 32,
   parameter int          PC_W         = 32,
   parameter bit          SKID         = 1'b1,
   parameter logic [31:0] BUBBLE_INSTR = INST_NOP
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [PC_W-1:0]   in_pc_next,
   input  logic [31:0]       in_instr,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [PC_W-1:0]   out_pc_next,
   output logic [31:0]       out_instr,
   output logic [DATA_W-1:0] out_data,
   output logic [15:0]       stall_cnt,
   output stage_state_t      dbg_state
);

   localparam int ENTRY_W = 2 * PC_W + 32 + DATA_W;
   localparam logic [ENTRY_W-1:0] BUBBLE_ENTRY =
      {{PC_W{1'b0}}, {PC_W{1'b0}}, BUBBLE_INSTR, {DATA_W{1'b0}}};

   stage_state_t       state_q, state_d;
   logic [ENTRY_W-1:0] main_q, main_d;
   logic [ENTRY_W-1:0] skid_q;
   logic [ENTRY_W-1:0] in_entry;
   logic               out_valid_q;
   logic               skid_load;
   logic               in_xfer, out_xfer;
   logic [15:0]        stall_q;

   assign in_entry = {in_pc, in_pc_next, in_instr, in_data};
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid_q && out_ready;

   // Next occupancy and next head entry; flush overrides every transfer
   always_comb begin
      state_d   = state_q;
      main_d    = main_q;
      skid_load = 1'b0;
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = BUBBLE_ENTRY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_xfer) begin
                  main_d  = in_entry;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_xfer && out_xfer) begin
                  main_d = in_entry;
               end else if (in_xfer) begin
                  // only reachable with a skid buffer; without one, in_ready
                  // follows out_ready while ONE
                  if (SKID) begin
                     skid_load = 1'b1;
                     state_d   = ST_TWO;
                  end
               end else if (out_xfer) begin
                  main_d  = BUBBLE_ENTRY;
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (out_xfer) begin
                  main_d  = skid_q;
                  state_d = ST_ONE;
               end
            end
            default: begin
               main_d  = BUBBLE_ENTRY;
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // State, head entry and head-valid registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_EMPTY;
         main_q      <= BUBBLE_ENTRY;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         out_valid_q <= (state_d != ST_EMPTY);
      end
   end

   generate
      if (SKID) begin : g_skid
         logic in_ready_q;

         // Second entry: captures the one transfer that lands while the head
         // is back-pressured, returns to bubble once it moves into main
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               skid_q <= BUBBLE_ENTRY;
            end else if (flush) begin
               skid_q <= BUBBLE_ENTRY;
            end else if (skid_load) begin
               skid_q <= in_entry;
            end else if (state_q == ST_TWO && out_xfer) begin
               skid_q <= BUBBLE_ENTRY;
            end
         end

         // Registered ready: low exactly while both entries are occupied
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               in_ready_q <= 1'b1;
            end else begin
               in_ready_q <= (state_d != ST_TWO);
            end
         end

         assign in_ready = in_ready_q;
      end else begin : g_no_skid
         assign skid_q   = BUBBLE_ENTRY;
         assign in_ready = (state_q == ST_EMPTY) || out_ready;
      end
   endgenerate

   // Count cycles where the head is offered but refused; sticks at max
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= 16'd0;
      end else if (out_valid_q && !out_ready && !flush) begin
         stall_q <= sat_inc16(stall_q);
      end
   end

   assign out_valid = out_valid_q;
   assign {out_pc, out_pc_next, out_instr, out_data} = main_q;
   assign stall_cnt = stall_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one skid instance and one flow-through instance,
// each with an expected-entry queue checked by its own output monitor.
module tb_pipe_stage_reg;
   import pipe_stage_reg_pkg::*;

   localparam int DW = 16;
   localparam int PW = 32;
   localparam int EW = 2 * PW + 32 + DW;
   localparam logic [31:0] NOP = 32'h00000013;

   int n_checks = 0;
   int n_fail   = 0;

   logic clk = 1'b0;
   logic rst = 1'b0;

   // ---- clock / reset ----
   always #5 clk = ~clk;

   // ---- skid instance signals ----
   logic          s_flush = 0, s_in_valid = 0, s_in_ready, s_out_valid, s_out_ready = 0;
   logic [PW-1:0] s_in_pc = 0, s_in_pc_next = 0, s_out_pc, s_out_pc_next;
   logic [31:0]   s_in_instr = 0, s_out_instr;
   logic [DW-1:0] s_in_data = 0, s_out_data;
   logic [15:0]   s_stall;
   stage_state_t  s_state;

   // ---- flow-through instance signals ----
   logic          f_flush = 0, f_in_valid = 0, f_in_ready, f_out_valid, f_out_ready = 0;
   logic [PW-1:0] f_in_pc = 0, f_in_pc_next = 0, f_out_pc, f_out_pc_next;
   logic [31:0]   f_in_instr = 0, f_out_instr;
   logic [DW-1:0] f_in_data = 0, f_out_data;
   logic [15:0]   f_stall;
   stage_state_t  f_state;

   logic [EW-1:0] s_exp_q[$];
   logic [EW-1:0] f_exp_q[$];

   pipe_stage_reg #(.DATA_W(DW), .PC_W(PW), .SKID(1'b1)) u_skid (
      .clk(clk), .rst(rst), .flush(s_flush),
      .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_pc(s_in_pc), .in_pc_next(s_in_pc_next), .in_instr(s_in_instr), .in_data(s_in_data),
      .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_pc(s_out_pc), .out_pc_next(s_out_pc_next), .out_instr(s_out_instr), .out_data(s_out_data),
      .stall_cnt(s_stall), .dbg_state(s_state)
   );

   pipe_stage_reg #(.DATA_W(DW), .PC_W(PW), .SKID(1'b0)) u_flow (
      .clk(clk), .rst(rst), .flush(f_flush),
      .in_valid(f_in_valid), .in_ready(f_in_ready),
      .in_pc(f_in_pc), .in_pc_next(f_in_pc_next), .in_instr(f_in_instr), .in_data(f_in_data),
      .out_valid(f_out_valid), .out_ready(f_out_ready),
      .out_pc(f_out_pc), .out_pc_next(f_out_pc_next), .out_instr(f_out_instr), .out_data(f_out_data),
      .stall_cnt(f_stall), .dbg_state(f_state)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---- driver tasks ----
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic s_set_in(input logic v, input logic [31:0] pc);
      s_in_valid   = v;
      s_in_pc      = pc;
      s_in_pc_next = pc + 32'd4;
      s_in_instr   = {pc[19:0], 12'h093};
      s_in_data    = pc[15:0] ^ 16'h5A5A;
   endtask

   task automatic f_set_in(input logic v, input logic [31:0] pc);
      f_in_valid   = v;
      f_in_pc      = pc;
      f_in_pc_next = pc + 32'd4;
      f_in_instr   = {pc[19:0], 12'h113};
      f_in_data    = pc[15:0] ^ 16'hC3C3;
   endtask

   // ---- scoreboard monitors: pop on out-transfer, push on in-transfer ----
   always @(negedge clk) begin
      if (rst) begin
         if (s_flush) begin
            s_exp_q.delete();
         end else begin
            if (s_out_valid && s_out_ready) begin
               if (s_exp_q.size() == 0)
                  check("s_unexpected_out", {s_out_pc, s_out_pc_next}, 128'h0);
               else
                  check("s_out_entry", {s_out_pc, s_out_pc_next, s_out_instr, s_out_data},
                        s_exp_q.pop_front());
            end
            if (s_in_valid && s_in_ready)
               s_exp_q.push_back({s_in_pc, s_in_pc_next, s_in_instr, s_in_data});
         end
         if (!s_out_valid)
            check("s_bubble", {s_out_pc, s_out_pc_next, s_out_instr, s_out_data},
                  {64'h0, NOP, 16'h0});
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         if (f_flush) begin
            f_exp_q.delete();
         end else begin
            if (f_out_valid && f_out_ready) begin
               if (f_exp_q.size() == 0)
                  check("f_unexpected_out", {f_out_pc, f_out_pc_next}, 128'h0);
               else
                  check("f_out_entry", {f_out_pc, f_out_pc_next, f_out_instr, f_out_data},
                        f_exp_q.pop_front());
            end
            if (f_in_valid && f_in_ready)
               f_exp_q.push_back({f_in_pc, f_in_pc_next, f_in_instr, f_in_data});
         end
         if (!f_out_valid)
            check("f_bubble", {f_out_pc, f_out_pc_next, f_out_instr, f_out_data},
                  {64'h0, NOP, 16'h0});
      end
   end

   // ---- directed stimulus ----
   initial begin
      int waited;

      // reset values
      #12;
      check("rst_s_out_valid", s_out_valid, 1'b0);
      check("rst_s_out_instr", s_out_instr, NOP);
      check("rst_s_in_ready",  s_in_ready,  1'b1);
      check("rst_s_stall",     s_stall,     16'd0);
      check("rst_s_state",     s_state,     ST_EMPTY);
      check("rst_f_out_valid", f_out_valid, 1'b0);
      check("rst_f_in_ready",  f_in_ready,  1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      step(); step();
      check("idle_s_out_valid", s_out_valid, 1'b0);
      check("idle_s_in_ready",  s_in_ready,  1'b1);

      // SKID=1 stream 0x0,0x4,0x8: one-cycle latency, no gaps
      s_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_set_in(1'b1, 32'(i * 4));
         step();
         check("stream_valid", s_out_valid, 1'b1);
         check("stream_pc",    s_out_pc,    32'(i * 4));
      end

      // back-pressure 4 cycles: absorb 0xC, then hold 0x10 off
      s_out_ready = 1'b0;
      s_set_in(1'b1, 32'hC);
      step();
      check("bp_in_ready_e1", s_in_ready, 1'b0);
      check("bp_state_e1",    s_state,    ST_TWO);
      s_set_in(1'b1, 32'h10);
      step(); step(); step();
      check("bp_in_ready_e4", s_in_ready, 1'b0);
      check("bp_head_pc",     s_out_pc,   32'h8);
      check("bp_stall_cnt",   s_stall,    16'd4);

      // drain in order: 0x8 out, skid 0xC to head, then 0x10 accepted
      s_out_ready = 1'b1;
      step();
      check("drain_pc_c",     s_out_pc,   32'hC);
      check("drain_in_ready", s_in_ready, 1'b1);
      step();
      check("drain_pc_10",    s_out_pc,   32'h10);
      s_set_in(1'b0, 32'h0);
      step();
      check("drain_empty",    s_out_valid, 1'b0);
      check("drain_stall",    s_stall,     16'd4);

      // fill to TWO, then flush together with in_valid at 0x20
      s_out_ready = 1'b0;
      s_set_in(1'b1, 32'h14);
      step();
      s_set_in(1'b1, 32'h18);
      step();
      check("pre_flush_state", s_state, ST_TWO);
      s_flush = 1'b1;
      s_set_in(1'b1, 32'h20);
      step();
      check("flush_out_valid", s_out_valid, 1'b0);
      check("flush_out_instr", s_out_instr, NOP);
      check("flush_in_ready",  s_in_ready,  1'b1);
      check("flush_state",     s_state,     ST_EMPTY);
      // flush while EMPTY also discards a same-cycle in-transfer
      s_set_in(1'b1, 32'h24);
      step();
      check("flush_empty_valid", s_out_valid, 1'b0);
      s_flush = 1'b0;
      s_set_in(1'b0, 32'h0);
      s_out_ready = 1'b1;
      step(); step();
      check("post_flush_valid", s_out_valid, 1'b0);

      // reset mid-operation with two entries held
      s_out_ready = 1'b0;
      s_set_in(1'b1, 32'h28);
      step();
      s_set_in(1'b1, 32'h2C);
      step();
      s_set_in(1'b0, 32'h0);
      rst = 1'b0;
      #1;
      check("mid_rst_valid", s_out_valid, 1'b0);
      check("mid_rst_instr", s_out_instr, NOP);
      check("mid_rst_stall", s_stall,     16'd0);
      check("mid_rst_ready", s_in_ready,  1'b1);
      s_exp_q.delete();
      step();
      rst = 1'b1;
      step();

      // saturation: stall until 0xFFFE, then 3 more cycles
      s_set_in(1'b1, 32'h30);
      step();
      s_set_in(1'b0, 32'h0);
      waited = 0;
      while (s_stall != 16'hFFFE && waited < 70000) begin
         step();
         waited++;
      end
      check("sat_reach_fffe", s_stall, 16'hFFFE);
      step(); step(); step();
      check("sat_hold_ffff", s_stall, 16'hFFFF);
      s_out_ready = 1'b1;
      step();
      check("sat_no_clear", s_stall, 16'hFFFF);
      step();

      // SKID=0: full with out_ready=0 gives in_ready=0 the same cycle
      f_out_ready = 1'b0;
      f_set_in(1'b1, 32'h40);
      step();
      check("f_full_in_ready", f_in_ready, 1'b0);
      f_set_in(1'b1, 32'h44);
      step();
      check("f_hold_pc",       f_out_pc,   32'h40);
      check("f_hold_in_ready", f_in_ready, 1'b0);
      check("f_stall_cnt",     f_stall,    16'd1);
      f_out_ready = 1'b1;
      #1;
      check("f_comb_ready", f_in_ready, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         step();
         check("f_stream_pc",    f_out_pc,    32'(32'h40 + 4 * i));
         check("f_stream_valid", f_out_valid, 1'b1);
         check("f_stream_ready", f_in_ready,  1'b1);
         if (i < 4) f_set_in(1'b1, 32'(32'h44 + 4 * i));
         else       f_set_in(1'b0, 32'h0);
      end
      step();
      check("f_drain_empty", f_out_valid, 1'b0);
      step();

      // every accepted entry came out
      check("s_queue_empty", 32'(s_exp_q.size()), 32'd0);
      check("f_queue_empty", 32'(f_exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
